// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: double-buffered nibble frame, per-digit guard
// blanking, optional leading-zero blanking, registered anode and decoder-nibble outputs.
module seg7_scan_ctrl #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned GUARD_CYC   = 16,
  parameter int unsigned LZB         = 1
) (
  input  logic                    JM1222HM_clk,
  input  logic                    JM1222HM_rst,
  input  logic                    JM1222HM_en,
  input  logic                    JM1222HM_load,
  input  logic [4*NUM_DIGITS-1:0] JM1222HM_value,
  output logic [3:0]              JM1222HM_dig_val,
  output logic [NUM_DIGITS-1:0]   JM1222HM_an,
  output logic                    JM1222HM_frame,
  output logic                    JM1222HM_pending
);

  localparam int unsigned PW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CW = $clog2(REFRESH_DIV);
  localparam int unsigned BW = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {StIdle, StBlank, StShow} state_e;

  state_e                state_q;
  logic [PW-1:0]         ptr_q;
  logic [CW-1:0]         cnt_q;
  logic [BW-1:0]         disp_q;
  logic [BW-1:0]         pend_q;
  logic                  pending_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic [3:0]            dig_val_q;
  logic                  frame_q;

  logic                  slot_end;
  logic                  guard_end;
  logic                  wrap;
  logic [PW-1:0]         ptr_nxt;
  logic [BW-1:0]         disp_nxt;
  logic [NUM_DIGITS-1:0] blank;
  logic [NUM_DIGITS-1:0] an_show;

  function automatic logic [3:0] nib(input logic [BW-1:0] b, input logic [PW-1:0] idx);
    return b[4*idx +: 4];
  endfunction

  assign slot_end  = (cnt_q == CW'(REFRESH_DIV - 1));
  assign guard_end = (cnt_q == CW'(GUARD_CYC - 1));
  assign ptr_nxt   = (ptr_q == PW'(NUM_DIGITS - 1)) ? '0 : ptr_q + 1'b1;
  assign wrap      = (state_q == StShow) && JM1222HM_en && slot_end &&
                     (ptr_q == PW'(NUM_DIGITS - 1));
  // Nibble fetched for the next slot must already see the buffer swapped on a wrap edge.
  assign disp_nxt  = (wrap && pending_q) ? pend_q : disp_q;

  always_comb begin
    blank = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      logic all_zero;
      all_zero = 1'b1;
      for (int j = i; j < NUM_DIGITS; j++) begin
        if (disp_q[4*j +: 4] != 4'h0) all_zero = 1'b0;
      end
      blank[i] = (LZB != 0) && all_zero;
    end
  end

  always_comb begin
    an_show = '1;
    if (!blank[ptr_q]) an_show[ptr_q] = 1'b0;
  end

  always_ff @(posedge JM1222HM_clk) begin
    if (JM1222HM_rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      cnt_q     <= '0;
      disp_q    <= '0;
      pend_q    <= '0;
      pending_q <= 1'b0;
      an_q      <= '1;
      dig_val_q <= 4'h0;
      frame_q   <= 1'b0;
    end else begin
      frame_q <= 1'b0;

      if (JM1222HM_load) begin
        pend_q    <= JM1222HM_value;
        pending_q <= 1'b1;
      end
      // A load coinciding with the swap refills the pending buffer, so pending stays set.
      if (wrap && pending_q) begin
        disp_q <= pend_q;
        if (!JM1222HM_load) pending_q <= 1'b0;
      end

      if (!JM1222HM_en) begin
        state_q <= StIdle;
        ptr_q   <= '0;
        cnt_q   <= '0;
        an_q    <= '1;
      end else begin
        case (state_q)
          StIdle: begin
            state_q   <= StBlank;
            ptr_q     <= '0;
            cnt_q     <= '0;
            an_q      <= '1;
            dig_val_q <= nib(disp_nxt, '0);
          end
          StBlank: begin
            cnt_q <= cnt_q + 1'b1;
            if (guard_end) begin
              state_q <= StShow;
              an_q    <= an_show;
            end
          end
          StShow: begin
            if (slot_end) begin
              state_q   <= StBlank;
              cnt_q     <= '0;
              ptr_q     <= ptr_nxt;
              an_q      <= '1;
              dig_val_q <= nib(disp_nxt, ptr_nxt);
              frame_q   <= wrap;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= StIdle;
            an_q    <= '1;
          end
        endcase
      end
    end
  end

  assign JM1222HM_dig_val = dig_val_q;
  assign JM1222HM_an      = an_q;
  assign JM1222HM_frame   = frame_q;
  assign JM1222HM_pending = pending_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: two instances (LZB off/on) share one stimulus stream.
module tb_seg7_scan_ctrl;

  localparam int unsigned ND = 4;
  localparam int unsigned RD = 8;
  localparam int unsigned GC = 2;

  logic          clk;
  logic          rst;
  logic          en;
  logic          load;
  logic [4*ND-1:0] value;
  logic [3:0]    dig0, dig1;
  logic [ND-1:0] an0, an1;
  logic          frame0, frame1;
  logic          pend0, pend1;

  int n_cmp = 0;
  int n_fail = 0;
  logic [ND-1:0] prev_an0, prev_an1;
  logic [3:0]    prev_dig0, prev_dig1;
  logic [ND-1:0] seen0, seen1;
  int            nw;

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD_CYC(GC), .LZB(0)) u_dut (
    .JM1222HM_clk(clk), .JM1222HM_rst(rst), .JM1222HM_en(en), .JM1222HM_load(load),
    .JM1222HM_value(value), .JM1222HM_dig_val(dig0), .JM1222HM_an(an0),
    .JM1222HM_frame(frame0), .JM1222HM_pending(pend0)
  );

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD_CYC(GC), .LZB(1)) u_dut_lzb (
    .JM1222HM_clk(clk), .JM1222HM_rst(rst), .JM1222HM_en(en), .JM1222HM_load(load),
    .JM1222HM_value(value), .JM1222HM_dig_val(dig1), .JM1222HM_an(an1),
    .JM1222HM_frame(frame1), .JM1222HM_pending(pend1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n cycles, sampling 1 time unit after each rising edge, with per-cycle invariants.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      prev_an0 = an0; prev_dig0 = dig0;
      prev_an1 = an1; prev_dig1 = dig1;
      @(posedge clk);
      #1;
      chk("onehot_an0", 32'($countones(~an0) <= 1), 32'd1);
      chk("onehot_an1", 32'($countones(~an1) <= 1), 32'd1);
      if (an0 != '1 && prev_an0 != '1) chk("dig_stable0", 32'(dig0), 32'(prev_dig0));
      if (an1 != '1 && prev_an1 != '1) chk("dig_stable1", 32'(dig1), 32'(prev_dig1));
      seen0 = seen0 | ~an0;
      seen1 = seen1 | ~an1;
    end
  endtask

  task automatic wait_frame(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      tick(1);
      if (frame0) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic pulse_load(input logic [4*ND-1:0] v);
    load = 1'b1; value = v;
    tick(1);
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; value = '0;
    seen0 = '0; seen1 = '0;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_an", 32'(an0), 32'hF);
    chk("rst_dig", 32'(dig0), 32'h0);
    chk("rst_frame", 32'(frame0), 32'h0);
    chk("rst_pending", 32'(pend0), 32'h0);

    // Enable: two guard cycles, then digit 0 for six cycles.
    en = 1'b1;
    tick(1); chk("guard0_an", 32'(an0), 32'hF);
    tick(1); chk("guard1_an", 32'(an0), 32'hF);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("d0_an", 32'(an0), 32'hE);
      chk("d0_dig", 32'(dig0), 32'h0);
    end
    tick(1); chk("d1_guard_an", 32'(an0), 32'hF);
    wait_frame(nw); chk("first_frame", nw, 24);
    wait_frame(nw); chk("frame_period", nw, 32);

    // Load mid-frame: old data kept until the wrap.
    tick(10);
    pulse_load(16'h1234);
    chk("ld_pending", 32'(pend0), 32'h1);
    chk("ld_an_d1", 32'(an0), 32'hD);
    chk("ld_old_dig", 32'(dig0), 32'h0);
    wait_frame(nw); chk("ld_wrap_wait", nw, 21);
    chk("ld_pending_clr", 32'(pend0), 32'h0);
    chk("ld_wrap_dig", 32'(dig0), 32'h4);
    tick(2); chk("v_an0", 32'(an0), 32'hE); chk("v_dig0", 32'(dig0), 32'h4);
    tick(8); chk("v_an1", 32'(an0), 32'hD); chk("v_dig1", 32'(dig0), 32'h3);
    tick(8); chk("v_an2", 32'(an0), 32'hB); chk("v_dig2", 32'(dig0), 32'h2);
    tick(8); chk("v_an3", 32'(an0), 32'h7); chk("v_dig3", 32'(dig0), 32'h1);

    // Last load wins; then a load on the wrap edge itself.
    wait_frame(nw); chk("lw_wait0", nw, 6);
    tick(3);
    pulse_load(16'hAAAA);
    tick(5);
    pulse_load(16'h5555);
    chk("lw_pending", 32'(pend0), 32'h1);
    wait_frame(nw); chk("lw_wait1", nw, 22);
    chk("lw_dig", 32'(dig0), 32'h5);
    chk("lw_pending_clr", 32'(pend0), 32'h0);
    tick(2); chk("lw_show", 32'(dig0), 32'h5);
    tick(18);
    pulse_load(16'h0F0F);
    tick(10);
    load = 1'b1; value = 16'h9876;
    tick(1);
    load = 1'b0;
    chk("sim_frame", 32'(frame0), 32'h1);
    chk("sim_pending", 32'(pend0), 32'h1);
    chk("sim_dig_old_pend", 32'(dig0), 32'hF);
    wait_frame(nw); chk("sim_wait", nw, 32);
    chk("sim_dig_new", 32'(dig0), 32'h6);
    chk("sim_pending_clr", 32'(pend0), 32'h0);

    // Drop enable while digit 2 is lit, then re-enable.
    tick(19);
    chk("en_d2_an", 32'(an0), 32'hB);
    chk("en_d2_dig", 32'(dig0), 32'h8);
    en = 1'b0;
    tick(1); chk("en_off_an", 32'(an0), 32'hF); chk("en_off_frame", 32'(frame0), 32'h0);
    tick(3); chk("en_idle_an", 32'(an0), 32'hF);
    en = 1'b1;
    tick(1); chk("re_guard_an", 32'(an0), 32'hF); chk("re_dig", 32'(dig0), 32'h6);
    tick(2); chk("re_an", 32'(an0), 32'hE);
    wait_frame(nw); chk("re_frame", nw, 30);

    // Reset mid-frame with a value pending.
    pulse_load(16'hABCD);
    chk("pre_rst_pending", 32'(pend0), 32'h1);
    tick(5);
    rst = 1'b1;
    tick(1);
    chk("mrst_an", 32'(an0), 32'hF);
    chk("mrst_dig", 32'(dig0), 32'h0);
    chk("mrst_frame", 32'(frame0), 32'h0);
    chk("mrst_pending", 32'(pend0), 32'h0);
    rst = 1'b0;
    tick(1); chk("post_rst_an", 32'(an0), 32'hF); chk("post_rst_dig", 32'(dig0), 32'h0);
    tick(2); chk("post_rst_show", 32'(an0), 32'hE);
    wait_frame(nw); chk("post_rst_frame", nw, 30);
    chk("post_rst_disp", 32'(dig0), 32'h0);
    chk("post_rst_pend", 32'(pend0), 32'h0);

    // Leading-zero blanking on the LZB=1 instance.
    pulse_load(16'h0050);
    wait_frame(nw); chk("lzb_wait", 32'(nw > 0), 32'd1);
    seen0 = '0; seen1 = '0;
    tick(32);
    chk("lzb_0050_on", 32'(seen1), 32'h3);
    chk("lzb_0050_off", 32'(seen0), 32'hF);
    pulse_load(16'h0000);
    wait_frame(nw); chk("lzb_wait0", 32'(nw > 0), 32'd1);
    seen0 = '0; seen1 = '0;
    tick(32);
    chk("lzb_zero_on", 32'(seen1), 32'h1);
    chk("lzb_zero_off", 32'(seen0), 32'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
